// File: rtl/tpu_fc_pkg.sv
// Shared definitions for the fully-connected classifier stage: default sizes,
// FSM state encoding and the max-pool pixel packing convention.
package tpu_fc_pkg;

    localparam int unsigned FC_N_IN   = 144;
    localparam int unsigned FC_N_OUT  = 10;
    localparam int unsigned FC_ACC_W  = 32;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WT_W      = 8;
    localparam int unsigned GRID_W    = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fc_state_e;

    // Pixel (row, col) of the 12x12 pooled map is flat index row*12+col
    function automatic int unsigned pix_index(input int unsigned row, input int unsigned col);
        return row * GRID_W + col;
    endfunction

    function automatic int unsigned pix_lsb(input int unsigned p);
        return p * PIX_W;
    endfunction

endpackage

// File: rtl/tpu_fc_mac.sv
// Registered multiply-accumulate: unsigned pixel times signed weight, added to
// either the running sum or a freshly loaded bias. Wraps modulo 2^ACC_W.
module tpu_fc_mac
    import tpu_fc_pkg::*;
#(
    parameter int unsigned ACC_W = FC_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    load_i,
    input  logic signed [ACC_W-1:0] bias_i,
    input  logic [PIX_W-1:0]        act_i,
    input  logic signed [WT_W-1:0]  weight_i,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam int unsigned PROD_W = PIX_W + WT_W + 1;

    logic signed [PROD_W-1:0] act_ext_c;
    logic signed [PROD_W-1:0] wt_ext_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    always_comb begin
        act_ext_c = {{(PROD_W-PIX_W){1'b0}}, act_i};
        wt_ext_c  = {{(PROD_W-WT_W){weight_i[WT_W-1]}}, weight_i};
        prod_c    = act_ext_c * wt_ext_c;
        acc_d     = acc_q;
        if (en_i) begin
            acc_d = (load_i ? bias_i : acc_q)
                  + {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/tpu_fc_layer.sv
// Fully-connected classifier: N_OUT scores, one MAC per cycle, plus argmax.
// Define TPU_FC_RELU_EN to clamp scores at zero before storing/comparing.
module tpu_fc_layer
    import tpu_fc_pkg::*;
#(
    parameter int unsigned N_IN  = FC_N_IN,
    parameter int unsigned N_OUT = FC_N_OUT,
    parameter int unsigned ACC_W = FC_ACC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N_IN*PIX_W-1:0]        tensor_in,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_IN*N_OUT)-1:0] w_addr,
    input  logic signed [WT_W-1:0]       w_data,
    output logic [$clog2(N_OUT)-1:0]     b_addr,
    input  logic signed [ACC_W-1:0]      b_data,
    output logic [N_OUT*ACC_W-1:0]       scores,
    output logic [$clog2(N_OUT)-1:0]     class_idx
);

    localparam int unsigned WA_W  = $clog2(N_IN*N_OUT);
    localparam int unsigned IDX_W = $clog2(N_OUT);
    localparam int unsigned P_W   = $clog2(N_IN);

    fc_state_e               state_q, state_d;
    logic [IDX_W-1:0]        n_q, n_d;
    logic [P_W-1:0]          p_q, p_d;
    logic [N_IN*PIX_W-1:0]   tensor_q, tensor_d;
    logic [WA_W-1:0]         w_addr_q, w_addr_d;
    logic [IDX_W-1:0]        b_addr_q, b_addr_d;
    logic [N_OUT*ACC_W-1:0]  scores_q, scores_d;
    logic [IDX_W-1:0]        class_q, class_d;
    logic signed [ACC_W-1:0] max_q, max_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    mac_en_c;
    logic                    mac_load_c;
    logic [PIX_W-1:0]        act_c;
    logic signed [ACC_W-1:0] acc_c;
    logic signed [ACC_W-1:0] wr_val_c;

    assign act_c = tensor_q[pix_lsb(32'(p_q)) +: PIX_W];

    tpu_fc_mac #(.ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .en_i     (mac_en_c),
        .load_i   (mac_load_c),
        .bias_i   (b_data),
        .act_i    (act_c),
        .weight_i (w_data),
        .acc_o    (acc_c)
    );

`ifdef TPU_FC_RELU_EN
    assign wr_val_c = acc_c[ACC_W-1] ? '0 : acc_c;
`else
    assign wr_val_c = acc_c;
`endif

    // Addresses are issued one cycle ahead of the MAC that consumes their data
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        p_d        = p_q;
        tensor_d   = tensor_q;
        w_addr_d   = w_addr_q;
        b_addr_d   = b_addr_q;
        scores_d   = scores_q;
        class_d    = class_q;
        max_d      = max_q;
        done_d     = 1'b0;
        mac_en_c   = 1'b0;
        mac_load_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tensor_d = tensor_in;
                    n_d      = '0;
                    w_addr_d = '0;
                    b_addr_d = '0;
                    state_d  = ST_PRE;
                end
            end
            ST_PRE: begin
                p_d      = '0;
                w_addr_d = w_addr_q + WA_W'(1);
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                mac_en_c   = 1'b1;
                mac_load_c = (p_q == '0);
                if (p_q == P_W'(N_IN-1)) begin
                    state_d = ST_WRITE;
                end else begin
                    p_d = p_q + P_W'(1);
                    if (p_q < P_W'(N_IN-2)) w_addr_d = w_addr_q + WA_W'(1);
                end
            end
            ST_WRITE: begin
                scores_d[32'(n_q)*ACC_W +: ACC_W] = wr_val_c;
                if ((n_q == '0) || (wr_val_c > max_q)) begin
                    max_d   = wr_val_c;
                    class_d = n_q;
                end
                if (n_q == IDX_W'(N_OUT-1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    n_d      = n_q + IDX_W'(1);
                    b_addr_d = n_q + IDX_W'(1);
                    w_addr_d = w_addr_q + WA_W'(1);
                    state_d  = ST_PRE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PRE) || (state_d == ST_MAC) || (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            p_q      <= '0;
            tensor_q <= '0;
            w_addr_q <= '0;
            b_addr_q <= '0;
            scores_q <= '0;
            class_q  <= '0;
            max_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            p_q      <= p_d;
            tensor_q <= tensor_d;
            w_addr_q <= w_addr_d;
            b_addr_q <= b_addr_d;
            scores_q <= scores_d;
            class_q  <= class_d;
            max_q    <= max_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign scores    = scores_q;
    assign class_idx = class_q;

endmodule

// File: tb/tb_tpu_fc_layer.sv
// Directed bench for tpu_fc_layer with behavioural weight/bias memories.
module tb_tpu_fc_layer;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1151:0]      tensor_in;
    logic               busy;
    logic               done;
    logic [10:0]        w_addr;
    logic signed [7:0]  w_data;
    logic [3:0]         b_addr;
    logic signed [31:0] b_data;
    logic [319:0]       scores;
    logic [3:0]         class_idx;

    int tests = 0;
    int fails = 0;

    int                 wmode;
    logic signed [31:0] bias_mem [16];
    int w_prev, b_prev, w_viol, b_viol, done_cnt;

    tpu_fc_layer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tensor_in (tensor_in),
        .busy      (busy),
        .done      (done),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .scores    (scores),
        .class_idx (class_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [7:0] wt_of(input logic [10:0] a);
        case (wmode)
            1:       return 8'(int'(a) / 144);
            2:       return -8'sd128;
            default: return 8'sd1;
        endcase
    endfunction

    // Synchronous-read memories: data follows the address by one cycle
    always @(posedge clk) begin
        w_data <= wt_of(w_addr);
        b_data <= bias_mem[b_addr];
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) begin
            if (int'(w_addr) != w_prev && int'(w_addr) != w_prev + 1) w_viol++;
            if (int'(b_addr) != b_prev && int'(b_addr) != b_prev + 1) b_viol++;
            w_prev = int'(w_addr);
            b_prev = int'(b_addr);
        end
    end

    function automatic logic signed [31:0] sc(input int n);
        return scores[n*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int v);
        for (int p = 0; p < 144; p++) tensor_in[p*8 +: 8] = 8'(v);
    endtask

    task automatic clr_mon();
        w_prev   = 0;
        b_prev   = 0;
        w_viol   = 0;
        b_viol   = 0;
        done_cnt = 0;
    endtask

    task automatic run_once(output int lat);
        @(negedge clk);
        start = 1'b1;
        clr_mon();
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic signed [31:0] e;

        rst = 1'b1;
        start = 1'b0;
        tensor_in = '0;
        wmode = 0;
        for (int i = 0; i < 16; i++) bias_mem[i] = 0;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_waddr", 64'(w_addr), 0);
        chk("rst_baddr", 64'(b_addr), 0);
        chk("rst_scores_zero", 64'(scores === '0), 1);
        chk("rst_class", 64'(class_idx), 0);
        rst = 1'b0;

        // Uniform weights and pixels: equal scores, tie resolves to class 0
        set_pix(2);
        wmode = 0;
        run_once(lat);
        chk("t1_latency", lat, 1461);
        chk("t1_busy_in_done", 64'(busy), 0);
        for (int n = 0; n < 10; n++) chk($sformatf("t1_score%0d", n), sc(n), 288);
        chk("t1_class", 64'(class_idx), 0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 0);

        // Weight equals neuron index: score n = 144n, address walk checked
        set_pix(1);
        wmode = 1;
        run_once(lat);
        chk("t2_latency", lat, 1461);
        for (int n = 0; n < 10; n++) chk($sformatf("t2_score%0d", n), sc(n), 144 * n);
        chk("t2_class", 64'(class_idx), 9);
        chk("t2_waddr_steps", w_viol, 0);
        chk("t2_baddr_steps", b_viol, 0);
        chk("t2_waddr_last", w_prev, 1439);
        chk("t2_baddr_last", b_prev, 9);

        // Large negative products, one biased neuron
        set_pix(255);
        wmode = 2;
        bias_mem[3] = 100000;
        run_once(lat);
        for (int n = 0; n < 10; n++) begin
`ifdef TPU_FC_RELU_EN
            e = 0;
`else
            e = (n == 3) ? -32'sd4600160 : -32'sd4700160;
`endif
            chk($sformatf("t3_score%0d", n), sc(n), e);
        end
`ifdef TPU_FC_RELU_EN
        chk("t3_class", 64'(class_idx), 0);
`else
        chk("t3_class", 64'(class_idx), 3);
`endif

        // Accumulator wrap on neuron 7
        set_pix(1);
        wmode = 0;
        for (int n = 0; n < 10; n++) bias_mem[n] = 10 * n;
        bias_mem[7] = 32'sh7FFFFFFF;
        run_once(lat);
        for (int n = 0; n < 10; n++) begin
            if (n == 7) begin
`ifdef TPU_FC_RELU_EN
                e = 0;
`else
                e = 32'sh8000008F;
`endif
            end else begin
                e = 144 + 10 * n;
            end
            chk($sformatf("t5_score%0d", n), sc(n), e);
        end
        chk("t5_class", 64'(class_idx), 9);

        // Reset mid-run aborts without a done pulse
        for (int n = 0; n < 16; n++) bias_mem[n] = 0;
        set_pix(2);
        @(negedge clk);
        start = 1'b1;
        clr_mon();
        @(negedge clk);
        start = 1'b0;
        repeat (498) @(negedge clk);
        chk("t4_busy_before", 64'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy_after_rst", 64'(busy), 0);
        chk("t4_scores_zero", 64'(scores === '0), 1);
        chk("t4_class", 64'(class_idx), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_idle_busy", 64'(busy), 0);
        run_once(lat);
        chk("t4_rerun_latency", lat, 1461);
        chk("t4_rerun_score0", sc(0), 288);
        chk("t4_rerun_score9", sc(9), 288);

        // start held high: one run per 1462 cycles, tensor latched at accept
        @(negedge clk);
        set_pix(3);
        start = 1'b1;
        clr_mon();
        lat = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == 100) set_pix(5);
        end
        chk("t6_first_latency", lat, 1461);
        chk("t6_first_score0", sc(0), 432);
        chk("t6_first_score5", sc(5), 432);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 3000);
        start = 1'b0;
        chk("t6_period", lat, 1462);
        chk("t6_second_score0", sc(0), 720);
        chk("t6_second_score9", sc(9), 720);
        chk("t6_class", 64'(class_idx), 0);
        repeat (3) @(negedge clk);
        chk("t6_no_third_run", 64'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
